// File: rtl/morse_keyer.sv
// morse_keyer: serializes an MSB-aligned keying pattern one bit per time unit
// and flags each tone unit as part of an isolated (short) or joined (long) element.
module morse_keyer #(
  parameter int WIDTH    = 10,
  parameter int TICK_DIV = 25000000,
  parameter int LEN_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             tone,
  output logic             short_el,
  output logic             long_el,
  output logic             tick
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [LEN_W-1:0] rem, rem_nx, len_c;
  logic [DW-1:0] div, div_nx;
  logic prev, prev_nx, run, nxt;
  assign len_c = len > LEN_W'(WIDTH) ? LEN_W'(WIDTH) : len;
  assign run = state == RUN;
  assign tick = run && div == DW'(TICK_DIV - 1);
  // the next bit only counts while it is still inside the captured length
  assign nxt = rem > LEN_W'(1) && sr[WIDTH-2];
  assign busy = run;
  assign done = state == FIN;
  assign tone = run & sr[WIDTH-1];
  assign short_el = tone & ~prev & ~nxt;
  assign long_el = tone & (prev | nxt);
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    rem_nx = rem;
    div_nx = div;
    prev_nx = prev;
    case (state)
      IDLE: begin
        div_nx = '0;
        if (start && !abort) begin
          sr_nx = pattern;
          rem_nx = len_c;
          prev_nx = 1'b0;
          state_nx = len_c == '0 ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
          div_nx = '0;
        end else if (tick) begin
          sr_nx = {sr[WIDTH-2:0], 1'b0};
          rem_nx = rem - LEN_W'(1);
          div_nx = '0;
          prev_nx = sr[WIDTH-1];
          state_nx = rem == LEN_W'(1) ? FIN : RUN;
        end else begin
          div_nx = div + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      rem <= '0;
      div <= '0;
      prev <= 1'b0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      rem <= rem_nx;
      div <= div_nx;
      prev <= prev_nx;
    end
  end
endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: scoreboard bench for two builds (TICK_DIV=4 and TICK_DIV=1)
// with a run-length based reference model.
module tb_morse_keyer;
  logic clk = 1'b0, rst_n = 1'b1;
  logic st0 = 1'b0, ab0 = 1'b0, st1 = 1'b0, ab1 = 1'b0;
  logic [9:0] pat0 = '0, pat1 = '0;
  logic [3:0] ln0 = '0, ln1 = '0;
  logic busy0, done0, tone0, sh0, lg0, tk0;
  logic busy1, done1, tone1, sh1, lg1, tk1;
  logic [5:0] q0[$], q1[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  morse_keyer #(.WIDTH(10), .TICK_DIV(4)) dut4 (
    .clk(clk), .reset(rst_n), .start(st0), .abort(ab0), .pattern(pat0), .len(ln0),
    .busy(busy0), .done(done0), .tone(tone0), .short_el(sh0), .long_el(lg0), .tick(tk0));
  morse_keyer #(.WIDTH(10), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(rst_n), .start(st1), .abort(ab1), .pattern(pat1), .len(ln1),
    .busy(busy1), .done(done1), .tone(tone1), .short_el(sh1), .long_el(lg1), .tick(tk1));
  task automatic cmp(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got busy,done,tone,short,long,tick=%b expected %b", nm, $time, act, exp);
    end
  endtask
  // monitor: one expected output vector per cycle; an empty queue means idle (all 0)
  always @(posedge clk) begin : mon
    logic [5:0] e0, e1;
    #1;
    e0 = q0.size() != 0 ? q0.pop_front() : 6'b0;
    e1 = q1.size() != 0 ? q1.pop_front() : 6'b0;
    cmp("div4", {busy0, done0, tone0, sh0, lg0, tk0}, e0);
    cmp("div1", {busy1, done1, tone1, sh1, lg1, tk1}, e1);
  end
  task automatic push(input int s, input logic [5:0] v);
    if (s != 0) q1.push_back(v);
    else q0.push_back(v);
  endtask
  // reference: element class from the length of the run of 1s each unit sits in
  task automatic play(input int s, input logic [9:0] p, input logic [3:0] l);
    int n, t, a, e;
    bit b[10];
    n = l > 10 ? 10 : int'(l);
    t = s != 0 ? 1 : 4;
    for (int k = 0; k < 10; k++) b[k] = k < n ? p[9-k] : 1'b0;
    for (int k = 0; k < n; k++) begin
      a = k;
      while (a > 0 && b[a-1]) a--;
      e = k;
      while (e < n - 1 && b[e+1]) e++;
      for (int c = 0; c < t; c++)
        push(s, {1'b1, 1'b0, b[k], b[k] && e == a, b[k] && e > a, c == t - 1});
    end
    push(s, 6'b010000);
    if (s != 0) begin pat1 = p; ln1 = l; st1 = 1'b1; end
    else begin pat0 = p; ln0 = l; st0 = 1'b1; end
    @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
    pat0 = 10'($urandom);
    pat1 = 10'($urandom);
    ln0 = 4'($urandom_range(0, 15));
    ln1 = 4'($urandom_range(0, 15));
  endtask
  task automatic wait_idle(input int s);
    int n = 0;
    while ((s != 0 ? q1.size() : q0.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d pending=%0d required 0", s, s != 0 ? q1.size() : q0.size());
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    play(0, 10'b1011000000, 5); wait_idle(0);
    play(0, 10'b1111111111, 15); wait_idle(0);
    play(0, 10'b0000000001, 10); wait_idle(0);
    play(0, 10'b1100000000, 1); wait_idle(0);
    play(0, 10'b1111111111, 0); wait_idle(0);
    play(0, 10'b1011000000, 5);
    repeat (5) @(negedge clk);
    st0 = 1'b1; pat0 = 10'b0101010101; ln0 = 4'd3;
    @(negedge clk);
    st0 = 1'b0;
    wait_idle(0);
    st0 = 1'b1; ab0 = 1'b1; pat0 = 10'b1111111111; ln0 = 4'd4;
    @(negedge clk);
    st0 = 1'b0; ab0 = 1'b0;
    repeat (2) @(negedge clk);
    play(0, 10'b1111100000, 10);
    repeat (9) @(negedge clk);
    ab0 = 1'b1;
    q0.delete();
    @(negedge clk);
    ab0 = 1'b0;
    @(negedge clk);
    play(0, 10'b1010101010, 4); wait_idle(0);
    play(0, 10'b1111111111, 10);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    q0.delete();
    #1 cmp("async_reset", {busy0, done0, tone0, sh0, lg0, tk0}, 6'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      play(0, 10'($urandom), 4'($urandom_range(0, 15)));
      wait_idle(0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    play(1, 10'b1010000000, 3); wait_idle(1);
    play(1, 10'b0000000000, 0); wait_idle(1);
    for (int i = 0; i < 30; i++) begin
      play(1, 10'($urandom), 4'($urandom_range(0, 15)));
      wait_idle(1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/morse_keyer.md
# morse_keyer

Parametrised Morse element serializer for the audio/display path. It accepts an MSB-aligned keying pattern and plays it out one bit per time unit. Each unit lasts a programmable number of clock cycles. For every unit it drives a raw tone key plus decoded short/long element flags. A start/busy/done handshake lets the control datapath queue patterns from the register file, and an abort input cancels playback.

## Interface
- WIDTH, 10: pattern width in bits (≥2).
- TICK_DIV, 25000000: clock cycles per time unit (≥1).
- LEN_W, $clog2(WIDTH+1): width of the length field.

- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  input  1  request playback; sampled only in IDLE.
- abort  input  1  synchronous cancel; highest priority after reset.
- pattern  input  WIDTH  keying bits, MSB played first; 1 = tone, 0 = silence.
- len  input  LEN_W  number of valid bits from MSB; values > WIDTH are clamped to WIDTH.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse after the last unit completes.
- tone  output  1  current unit bit.
- short  output  1  current unit belongs to an isolated 1 (run length 1).
- long  output  1  current unit belongs to a run of ≥2 consecutive 1s.
- tick  output  1  one-cycle pulse on the last cycle of each unit.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - On start=1, capture pattern into a shift register and latch len (clamped) into a remaining-count register.
  - If the clamped len is 0, go to FIN; otherwise go to RUN.
  - The divider counter clears to 0.
- RUN:
  - The divider counts 0..TICK_DIV-1. tick=1 when divider==TICK_DIV-1.
  - On tick, shift left by 1 (zero fill), decrement remaining, and clear the divider.
  - When remaining reaches 0 on tick, go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- Element classification uses the current bit b, previous played bit p, and next bit n:
  - p is 0 for the first unit.
  - n is 0 if it lies beyond len.
  - short = b & ~p & ~n.
  - long = b & (p | n).
  - tone = b.
- All of tone, short and long are 0 outside RUN.
- start while busy or in FIN is ignored and not queued.
- pattern and len changes after capture have no effect.
- abort=1 in RUN or FIN returns to IDLE next edge, with no done pulse and all outputs 0. abort in IDLE has no effect and overrides start.

## Timing
- Reset values: state IDLE. busy, done, tone, short, long and tick are all 0. Shift register, divider and remaining count are 0.
- Start accepted at edge E0: busy=1 and unit 0 is valid from the cycle after E0.
- Unit k occupies cycles 1+k·TICK_DIV .. (k+1)·TICK_DIV relative to E0.
- done occurs in cycle len·TICK_DIV+1, with busy=0 in that cycle. Next start is accepted one cycle later.
- len=0: done occurs in cycle 1, busy is never asserted, and tick never fires.
- TICK_DIV=1: tick is high every RUN cycle, and each unit lasts exactly one cycle.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- reset low mid-RUN: outputs go 0 asynchronously, and playback resumes only after a new start.

## Test plan
- Reset, then a simple pattern (WIDTH=10, TICK_DIV=4): hold reset=0 for 3 cycles, then release. Drive pattern=10'b1011000000, len=5, start pulse at E0.
  - Units tone=1,0,1,1,0, each 4 cycles long.
  - short is high in cycles 1–4; long is high in cycles 9–16.
  - tick fires at cycles 4, 8, 12, 16, 20. busy is high in cycles 1–20. done is high in cycle 21 only.
- Clamp and tail: pattern=10'b1111111111, len=15.
  - len is clamped to 10, and long is high in all 40 RUN cycles.
  - pattern=10'b0000000001 with len=10 gives short in the last unit only.
  - pattern=10'b1100000000 with len=1 gives short in unit 0, because bit 1 is beyond len.
- Zero length: len=0 with start.
  - done in cycle 1, busy never high, tone/short/long stay 0.
- Start while busy: a second start with a different pattern in cycle 6 of a len=5 run.
  - Ignored; the original sequence completes unchanged, with done in cycle 21.
- Abort and reset mid-run:
  - abort=1 in cycle 10: all outputs are 0 from cycle 11, no done pulse, and a start in cycle 12 is accepted.
  - Separately, reset=0 asynchronously mid-unit: outputs drop to 0 before the next clock edge.
- TICK_DIV=1 build: pattern=10'b1010000000, len=3.
  - Cycle 1: tone=1, short=1. Cycle 2: tone=0. Cycle 3: tone=1, short=1.
  - tick is high in cycles 1–3. done is high in cycle 4.
